mem_arbiter_256_16: RTL

//  Shares one single-port 256x16 memory (block RAM, read-first or write-first, or distributed
//  RAM with output register) between two requesters, A and B, using round-robin arbitration.

---
 rtl/mem_arbiter_256_16.sv | 113 +++++++++++
 1 files changed

// File: rtl/mem_arbiter_256_16.sv
// rtl/mem_arbiter_256_16.sv - round-robin arbiter sharing one single-port RAM between requesters A and B
// Zero-fills the RAM after reset, then grants one access per cycle and tags reads back to their issuer.
module mem_arbiter_256_16 #(
   parameter int AW       = 8,
   parameter int DW       = 16,
   parameter int RD_LAT   = 1,
   parameter int CLR_INIT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wd,
   output logic          a_gnt,
   output logic          a_rvalid,
   output logic [DW-1:0] a_rdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wd,
   output logic          b_gnt,
   output logic          b_rvalid,
   output logic [DW-1:0] b_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_a,
   output logic [DW-1:0] mem_wd,
   input  logic [DW-1:0] mem_rd,
   output logic          init_done
);

   typedef enum logic {StInit, StArb} stateT;

   stateT             state, stateNext;
   logic [AW-1:0]     cnt;
   logic              rr;          // 0: A has priority, 1: B has priority
   logic [RD_LAT-1:0] tagValid;
   logic [RD_LAT-1:0] tagSide;     // 0: read belongs to A, 1: to B
   logic              initDoneReg;
   logic              grantA, grantB, rdIssue;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= (CLR_INIT != 0) ? StInit : StArb;
         cnt         <= '0;
         rr          <= 1'b0;
         tagValid    <= '0;
         tagSide     <= '0;
         initDoneReg <= (CLR_INIT == 0);
      end else begin
         state <= stateNext;
         if (state == StInit) begin
            if (cnt == '1) initDoneReg <= 1'b1;
            else           cnt         <= cnt + 1'b1;
         end
         if (grantA)      rr <= 1'b1;
         else if (grantB) rr <= 1'b0;
         for (int i = RD_LAT - 1; i > 0; i--) begin
            tagValid[i] <= tagValid[i-1];
            tagSide[i]  <= tagSide[i-1];
         end
         tagValid[0] <= rdIssue;
         tagSide[0]  <= grantB;
      end
   end

   always_comb begin
      stateNext = state;
      grantA    = 1'b0;
      grantB    = 1'b0;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_a     = '0;
      mem_wd    = '0;
      if (!rst) begin
         case (state)
            StInit: begin
               mem_en = 1'b1;
               mem_we = 1'b1;
               mem_a  = cnt;
               if (cnt == '1) stateNext = StArb;
            end
            default: begin
               grantA = a_req && (!b_req || !rr);
               grantB = b_req && (!a_req || rr);
               if (grantA) begin
                  mem_en = 1'b1;
                  mem_we = a_we;
                  mem_a  = a_addr;
                  mem_wd = a_wd;
               end else if (grantB) begin
                  mem_en = 1'b1;
                  mem_we = b_we;
                  mem_a  = b_addr;
                  mem_wd = b_wd;
               end
            end
         endcase
      end
   end

   assign rdIssue   = (grantA && !a_we) || (grantB && !b_we);
   assign a_gnt     = grantA;
   assign b_gnt     = grantB;
   // The RAM output is shared; the tag at the end of the pipe decides who sees it.
   assign a_rvalid  = !rst && tagValid[RD_LAT-1] && !tagSide[RD_LAT-1];
   assign b_rvalid  = !rst && tagValid[RD_LAT-1] &&  tagSide[RD_LAT-1];
   assign a_rdata   = mem_rd;
   assign b_rdata   = mem_rd;
   assign init_done = initDoneReg;

endmodule
